// File: rtl/sync_sel_mux.sv
// N-channel registered mux with a valid/ready select handshake and a break-before-make gap.
// Optional feature: define SEL_CNT_EN to add the saturating switch_cnt output.
module sync_sel_mux #(
    parameter int unsigned         WIDTH      = 1,
    parameter int unsigned         N_CH       = 4,
    parameter int unsigned         SEL_W      = $clog2(N_CH),
    parameter int unsigned         GAP_CYCLES = 2,
    parameter logic [WIDTH-1:0]    IDLE_VAL   = '0,
    parameter int unsigned         RESET_SEL  = 0,
    parameter int unsigned         CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*WIDTH-1:0]  data_in,
    input  logic [SEL_W-1:0]       sel_in,
    input  logic                   sel_valid,
    output logic                   sel_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic [SEL_W-1:0]       cur_sel,
    output logic                   switching,
`ifdef SEL_CNT_EN
    output logic [CNT_W-1:0]       switch_cnt,
`endif
    output logic                   sel_err
);

    localparam int unsigned        GCNT_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned        N_PAD    = 1 << SEL_W;
    localparam logic [SEL_W-1:0]   RST_SEL  = SEL_W'(RESET_SEL);
    localparam logic [GCNT_W-1:0]  GAP_LOAD = GCNT_W'(GAP_CYCLES - 1);

    typedef enum logic {
        ACTIVE = 1'b0,
        GAP    = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    pend_q, pend_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    logic [SEL_W-1:0]    cur_sel_d;
    logic [WIDTH-1:0]    data_d;
    logic                switching_d;
    logic                sel_err_d;
    logic                cnt_inc;

    // Channel lookup padded to a power of two so any select value indexes safely.
    logic [WIDTH-1:0]    ch_data [N_PAD];

    for (genvar k = 0; k < N_PAD; k++) begin : g_ch
        if (k < N_CH) begin : g_real
            assign ch_data[k] = data_in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_data[k] = IDLE_VAL;
        end
    end

    assign sel_ready = (state_q == ACTIVE);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        gcnt_d      = gcnt_q;
        cur_sel_d   = cur_sel;
        data_d      = ch_data[cur_sel];
        switching_d = 1'b0;
        sel_err_d   = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            ACTIVE: begin
                if (sel_valid) begin
                    if (32'(sel_in) >= N_CH) begin
                        sel_err_d = 1'b1;
                    end else if (sel_in != cur_sel) begin
                        if (GAP_CYCLES == 0) begin
                            cur_sel_d = sel_in;
                            data_d    = ch_data[sel_in];
                            cnt_inc   = 1'b1;
                        end else begin
                            pend_d      = sel_in;
                            gcnt_d      = GAP_LOAD;
                            state_d     = GAP;
                            data_d      = IDLE_VAL;
                            switching_d = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (gcnt_q == '0) begin
                    state_d   = ACTIVE;
                    cur_sel_d = pend_q;
                    data_d    = ch_data[pend_q];
                    cnt_inc   = 1'b1;
                end else begin
                    gcnt_d      = gcnt_q - GCNT_W'(1);
                    data_d      = IDLE_VAL;
                    switching_d = 1'b1;
                end
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
    end

    // Gap bookkeeping exists only when a gap is configured.
    if (GAP_CYCLES > 0) begin : g_gap
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ACTIVE;
                pend_q  <= RST_SEL;
                gcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                pend_q  <= pend_d;
                gcnt_q  <= gcnt_d;
            end
        end
    end else begin : g_no_gap
        assign state_q = ACTIVE;
        assign pend_q  = RST_SEL;
        assign gcnt_q  = '0;
        logic unused_gap;
        assign unused_gap = ^{state_d, pend_d, gcnt_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel   <= RST_SEL;
            data_out  <= IDLE_VAL;
            switching <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            cur_sel   <= cur_sel_d;
            data_out  <= data_d;
            switching <= switching_d;
            sel_err   <= sel_err_d;
        end
    end

`ifdef SEL_CNT_EN
    // Completed-switch counter; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_cnt <= '0;
        end else if (cnt_inc && (switch_cnt != '1)) begin
            switch_cnt <= switch_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_inc;
    assign unused_cnt_inc = cnt_inc;
`endif

endmodule
